// File: rtl/pkt_check_pkg.sv
// Shared definitions for the packet format/sequence checker:
// one-hot state encoding and error-code encoding.
package pkt_check_pkg;

  localparam int STATE_W = 5;

  typedef enum logic [STATE_W-1:0] {
    RESET    = 5'h01,
    FIRSTPKT = 5'h02,
    REGPKT   = 5'h04,
    F_ERR    = 5'h08,
    SEQ_ERR  = 5'h10
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_FMT  = 2'd1,
    ERR_SEQ  = 2'd2
  } err_code_t;

endpackage

// File: rtl/pkt_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
// The clear takes priority over a coincident increment.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, stick at all-ones, clear wins over increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pkt_seq_checker.sv
// Packet format/sequence checker at the ingress of the packet path.
// Checks the header field (top word) and sequence field (bottom word) of
// every valid bus word, flags errors, optionally resynchronises the expected
// sequence number and keeps saturating error counters.
// Optional build macro PKT_SEQ_CHECKER_STATS_EN adds a saturating count of
// good words on output good_pkt_cnt.
module pkt_seq_checker
  import pkt_check_pkg::*;
#(
  parameter int                   BUS_SIZE      = 16,
  parameter int                   WORD_SIZE     = 4,
  parameter logic [WORD_SIZE-1:0] HEADER        = {WORD_SIZE{1'b1}},
  parameter int                   RESYNC        = 1,
  parameter int                   ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     data_valid,
  input  logic [BUS_SIZE-1:0]      data_in,
  input  logic                     cnt_clr,
  output logic                     error,
  output logic                     next_error,
  output logic [STATE_W-1:0]       state,
  output logic [STATE_W-1:0]       next_state,
  output logic [1:0]               err_code,
  output logic [WORD_SIZE-1:0]     expected_seq,
  output logic [ERR_CNT_WIDTH-1:0] fmt_err_cnt,
`ifdef PKT_SEQ_CHECKER_STATS_EN
  output logic [ERR_CNT_WIDTH-1:0] good_pkt_cnt,
`endif
  output logic [ERR_CNT_WIDTH-1:0] seq_err_cnt
);

  state_t                 state_q;
  state_t                 state_d;
  err_code_t              code_q;
  err_code_t              code_d;
  logic                   error_d;
  logic [WORD_SIZE-1:0]   exp_d;
  logic [WORD_SIZE-1:0]   hdr_field;
  logic [WORD_SIZE-1:0]   seq_field;
  logic                   fmt_bad;
  logic                   seq_bad;
  logic                   fmt_inc;
  logic                   seq_inc;
  logic                   good_word;

  // Only the top and bottom words are examined; the middle of the bus is
  // payload that passes by untouched.
  logic unused_data;
  assign unused_data = ^data_in;

  assign hdr_field = data_in[BUS_SIZE-1 -: WORD_SIZE];
  assign seq_field = data_in[WORD_SIZE-1:0];
  assign fmt_bad   = (hdr_field != HEADER);
  assign seq_bad   = (seq_field != expected_seq);

  assign state      = state_q;
  assign next_state = state_d;
  assign next_error = error_d;
  assign err_code   = code_q;

  // Next-state, next-error and counter-increment decode; error states last
  // one cycle and drop whatever word arrives meanwhile.
  always_comb begin
    state_d   = state_q;
    error_d   = error;
    code_d    = code_q;
    exp_d     = expected_seq;
    fmt_inc   = 1'b0;
    seq_inc   = 1'b0;
    good_word = 1'b0;
    case (state_q)
      RESET, FIRSTPKT, REGPKT: begin
        if (data_valid) begin
          if (fmt_bad) begin
            state_d = F_ERR;
            error_d = 1'b1;
            code_d  = ERR_FMT;
            fmt_inc = 1'b1;
          end else if (seq_bad) begin
            state_d = SEQ_ERR;
            error_d = 1'b1;
            code_d  = ERR_SEQ;
            seq_inc = 1'b1;
            if (RESYNC != 0) begin
              exp_d = seq_field + 1'b1;
            end
          end else begin
            state_d   = (state_q == RESET) ? FIRSTPKT : REGPKT;
            error_d   = 1'b0;
            code_d    = ERR_NONE;
            exp_d     = expected_seq + 1'b1;
            good_word = 1'b1;
          end
        end
      end
      F_ERR, SEQ_ERR: begin
        state_d = FIRSTPKT;
        error_d = 1'b0;
        code_d  = ERR_NONE;
      end
      default: begin
        state_d = RESET;
        error_d = 1'b0;
        code_d  = ERR_NONE;
      end
    endcase
  end

  // State, error flag, error code and expected sequence registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RESET;
      error        <= 1'b0;
      code_q       <= ERR_NONE;
      expected_seq <= '0;
    end else begin
      state_q      <= state_d;
      error        <= error_d;
      code_q       <= code_d;
      expected_seq <= exp_d;
    end
  end

  sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_fmt_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (fmt_inc),
    .count (fmt_err_cnt)
  );

  sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_seq_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (seq_inc),
    .count (seq_err_cnt)
  );

`ifdef PKT_SEQ_CHECKER_STATS_EN
  sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_good_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (good_word),
    .count (good_pkt_cnt)
  );
`else
  logic unused_good;
  assign unused_good = good_word;
`endif

endmodule

// File: doc/pkt_seq_checker.md
Name: pkt_seq_checker

Overview:
Parametrised successor to the packet format/sequence checker FSM. It checks each valid bus word for two fields:
- a header word in the MSB word;
- a sequence number in the LSB word.
It flags format and sequence errors, optionally resynchronises the expected sequence number after a sequence error, and keeps saturating error counters. It sits at the ingress of the packet path, ahead of the packet buffers.

Parameters:
BUS_SIZE, 16, data bus width in bits; must be a multiple of WORD_SIZE.
WORD_SIZE, 4, width of the header and sequence fields.
HEADER, {WORD_SIZE{1'b1}}, required value of data_in[BUS_SIZE-1 -: WORD_SIZE].
RESYNC, 1, 1 = on sequence error, expected sequence loads received+1; 0 = expected sequence holds.
ERR_CNT_WIDTH, 8, width of each saturating error counter.

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-low reset.
data_valid  in  1  data_in is evaluated only when 1.
data_in  in  BUS_SIZE  packet word.
cnt_clr  in  1  synchronous clear of both error counters.
error  out  1  registered error flag.
next_error  out  1  combinational next value of error.
state  out  5  registered one-hot state.
next_state  out  5  combinational next state.
err_code  out  2  registered: 0 none, 1 format, 2 sequence.
expected_seq  out  WORD_SIZE  registered expected sequence number.
fmt_err_cnt  out  ERR_CNT_WIDTH  saturating format-error count.
seq_err_cnt  out  ERR_CNT_WIDTH  saturating sequence-error count.

Behaviour:
- Reset (reset=0, asynchronous): state=RESET, error=0, err_code=0, expected_seq=0, both counters=0.
- Check definitions:
  - fmt_bad = header field != HEADER.
  - seq_bad = low word != expected_seq.
  - fmt_bad takes priority over seq_bad.
- A valid word is "good" when !fmt_bad && !seq_bad. Each good word in RESET, FIRSTPKT or REGPKT increments expected_seq modulo 2^WORD_SIZE (wraps F->0).
- States are one-hot: RESET=5'h01, FIRSTPKT=5'h02, REGPKT=5'h04, F_ERR=5'h08, SEQ_ERR=5'h10.
- RESET / FIRSTPKT / REGPKT:
  - data_valid=0: hold state, all registers hold.
  - fmt_bad: go to F_ERR, error=1, err_code=1, fmt_err_cnt+1, expected_seq unchanged.
  - seq_bad: go to SEQ_ERR, error=1, err_code=2, seq_err_cnt+1. expected_seq becomes data_in[WORD_SIZE-1:0]+1 if RESYNC=1, otherwise unchanged.
  - good word: RESET goes to FIRSTPKT; FIRSTPKT and REGPKT go to REGPKT.
- FIRSTPKT: error and err_code are cleared on entry. They are registered, so they read 0 while in FIRSTPKT.
- F_ERR / SEQ_ERR:
  - Each lasts exactly one cycle, then goes unconditionally to FIRSTPKT with next_error=0.
  - A valid word presented during an error state is dropped: no check, no counter change, no expected_seq change.
- Latency: error, err_code and the counters update at the edge following the offending valid word.
- Counters saturate at 2^ERR_CNT_WIDTH-1.
- cnt_clr=1 zeroes both counters at the next edge; if cnt_clr coincides with an increment, the clear wins.
- Reset asserted mid-operation (any state) returns immediately to the reset values. The first valid word after reset deassertion is checked against sequence 0.
- next_state and next_error are combinational and fully assigned on every path (no latches).
- Illegal (non-one-hot) state: next_state=RESET, next_error=0.

Optional Feature:
PKT_SEQ_CHECKER_STATS_EN.
- Defined: adds output good_pkt_cnt [ERR_CNT_WIDTH-1:0]. It is a saturating count of good words, is cleared by reset and cnt_clr, and shows the same clear-wins priority.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package pkt_check_pkg holds:
  - the one-hot state localparams (RESET, FIRSTPKT, REGPKT, F_ERR, SEQ_ERR) and the 5-bit state width;
  - the err_code encodings (ERR_NONE, ERR_FMT, ERR_SEQ).
- One natural sub-module: sat_counter (parameter WIDTH; inputs clk, reset, clr, inc; output count). It is instantiated twice, or three times with stats enabled.

Test Plan:
All cases use defaults (BUS 16, WORD 4, RESYNC=1) unless stated.
1. After reset, valid 0xF000, 0xF001, 0xF002 -> state RESET->FIRSTPKT->REGPKT->REGPKT; error=0 throughout; expected_seq=3.
2. In REGPKT with expected 3, valid 0xE003 -> F_ERR, error=1, err_code=1, fmt_err_cnt=1, expected_seq=3. Next cycle -> FIRSTPKT with error=0; then 0xF003 -> REGPKT.
3. In REGPKT with expected 3, valid 0xF005 -> SEQ_ERR, err_code=2, seq_err_cnt=1, expected_seq=6. With RESYNC=0: expected_seq stays 3.
4. Wrap: 17 consecutive good words 0xF000..0xF00F then 0xF000 -> no error, state REGPKT, expected_seq=1.
5. ERR_CNT_WIDTH=2: five format errors, each separated by recovery -> fmt_err_cnt stops at 3. cnt_clr asserted together with a sixth error -> fmt_err_cnt=0.
6. reset asserted asynchronously mid-REGPKT, with a valid word dropped during an error state beforehand -> outputs return to reset values immediately; the first word after release must be 0xF000.
